eq_band_mixer: RTL and testbench
================================

Name: eq_band_mixer

Overview:
- Downstream stage of the 8 band filters in the audio equalizer.
- On each input-rate sample strobe, it snapshots the 8 signed 16-bit band outputs and multiplies each by a per-band gain using one time-multiplexed multiplier.
- It accumulates the products, then rounds and saturates the sum to one 16-bit equalized output sample.
- Runs on the fast system clock, qualified by the same clk_enable that drives the band filters.

Parameters:
- NUM_BANDS, 8, number of band inputs; legal range 2..8.
- DATA_W, 16, band input and mix output width (signed).
- GAIN_W, 16, gain width; signed Q2.14, so 16384 = 1.0.
- FRAC_BITS, 14, fractional bits of the gain, removed after accumulation.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- clk_enable  in  1  global enable; the FSM and accumulator advance only when it is 1
- sample_valid  in  1  one-cycle strobe: band_in holds a new sample set
- band_in  in  NUM_BANDS*DATA_W  packed signed band outputs; band k at [k*DATA_W +: DATA_W]
- gain_wr_en  in  1  gain register write strobe
- gain_addr  in  3  band index for the write; writes with index >= NUM_BANDS are ignored
- gain_data  in  GAIN_W  signed Q2.14 gain value
- mix_out  out  DATA_W  signed mixed sample
- mix_valid  out  1  one-cycle pulse: mix_out has been updated
- busy  out  1  high while a sample is being processed
- overrun  out  1  sticky: a sample_valid was dropped
- clip  out  1  sticky: saturation occurred
- flag_clr  in  1  clears overrun and clip

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) forces:
  - outputs: mix_out=0, mix_valid=0, busy=0, overrun=0, clip=0;
  - internal state: FSM=IDLE, accumulator=0, all gains=16384.
- Reset in the middle of a computation aborts it; no mix_valid is produced for that sample.
- Gain bank:
  - a write on gain_wr_en takes effect at the next clk edge, independent of clk_enable.
  - On sample capture the gain bank is copied into a working set.
  - A write while busy therefore affects only the next sample.
- FSM states IDLE, MAC, OUT. Transitions occur only on edges with clk_enable=1.
  - IDLE: on sample_valid=1, latch band_in and the gain working set, clear the accumulator, set band index k=0, go to MAC, busy=1.
  - MAC: acc <= acc + band[k]*gain[k]. The product is 32-bit signed; the accumulator is 35-bit signed. When k=NUM_BANDS-1, go to OUT; otherwise k <= k+1.
  - OUT:
    - compute r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half toward +inf;
    - reduce r to DATA_W (see Optional Feature) and register it into mix_out;
    - mix_valid=1 for exactly one clk; busy=0; go to IDLE.
- Latency: sample accepted on enabled edge T; mix_valid is high in the cycle after enabled edge T+NUM_BANDS+1, i.e. 10 enabled edges for NUM_BANDS=8. With clk_enable permanently high, mix_valid is high in cycle T+10.
- Stall: with clk_enable=0 the state, accumulator and k are frozen. mix_valid still drops after one clk.
- A sample_valid while busy=1, or in the OUT cycle, is dropped and sets overrun. Processing continues unaffected.
- Simultaneous sample_valid with clk_enable=0 is ignored; it is not counted as overrun.
- Simultaneous flag_clr and a set event in the same cycle: the set event wins.
- mix_out holds its value between mix_valid pulses.

Optional Feature:
- Macro: EQ_MIX_SATURATE_EN.
- Defined: r outside [-32768, 32767] is clamped to the nearest bound and clip is set.
- Undefined: mix_out = r[DATA_W-1:0] (two's-complement wrap) and clip is tied to 0.

Test Plan:
- Reset defaults, all band_in=1000, sample_valid at T -> mix_valid only in cycle T+10, mix_out=8000, busy high for cycles T+1..T+9.
- Write gain_addr=3 gain_data=0, bands=1000 -> mix_out=7000. Then write gain0=8192 (0.5) -> next sample mix_out=6500.
- Rounding: gains all 0 except gain0=8192. band0=1 -> mix_out=1; band0=-1 -> mix_out=0; band0=-3 -> mix_out=-1.
- All bands=32767 at unity:
  - macro defined -> mix_out=32767, clip=1; flag_clr -> clip=0.
  - macro undefined -> mix_out=-8, clip=0.
- Overrun and stall:
  - sample_valid at T and at T+3 -> one mix_valid, overrun=1;
  - clk_enable low for 5 cycles mid-MAC -> mix_valid delayed by exactly 5 cycles with an unchanged result;
  - gain write at T+2 -> current result unchanged, next sample uses the new gain.
- rst asserted at T+4 mid-computation -> no mix_valid. mix_out=0, all gains back to 16384, and the next sample with bands=1000 yields 8000.

Source files
------------

// File: rtl/eq_band_mixer.sv
// Equalizer band mixer: weights the band filter outputs by per-band Q2.14 gains with one shared MAC,
// then rounds and reduces the sum to one output sample. Optional clamp: EQ_MIX_SATURATE_EN.
module eq_band_mixer #(
  parameter int unsigned NUM_BANDS = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned GAIN_W    = 16,
  parameter int unsigned FRAC_BITS = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_enable,
  input  logic                          sample_valid,
  input  logic [NUM_BANDS*DATA_W-1:0]   band_in,
  input  logic                          gain_wr_en,
  input  logic [2:0]                    gain_addr,
  input  logic [GAIN_W-1:0]             gain_data,
  output logic [DATA_W-1:0]             mix_out,
  output logic                          mix_valid,
  output logic                          busy,
  output logic                          overrun,
  output logic                          clip,
  input  logic                          flag_clr
);

  localparam int unsigned K_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int unsigned PROD_W = DATA_W + GAIN_W;
  localparam int unsigned ACC_W  = PROD_W + 3;

  localparam logic [K_W-1:0]          K_LAST = K_W'(NUM_BANDS - 1);
  localparam logic [GAIN_W-1:0]       G_UNIT = GAIN_W'(1 << FRAC_BITS);
  localparam logic signed [ACC_W-1:0] RND    = ACC_W'(1 << (FRAC_BITS - 1));
  localparam logic signed [ACC_W-1:0] MAX_V  = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] MIN_V  = ~MAX_V;

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t                     r_state, w_state_nxt;
  logic signed [DATA_W-1:0]   r_band   [NUM_BANDS];
  logic signed [GAIN_W-1:0]   r_gain   [NUM_BANDS];
  logic signed [GAIN_W-1:0]   r_gain_w [NUM_BANDS];
  logic [K_W-1:0]             r_k;
  logic signed [ACC_W-1:0]    r_acc;
  logic [DATA_W-1:0]          r_mix_out;
  logic                       r_mix_valid, r_busy, r_overrun, r_clip;

  logic                       w_capture, w_mac, w_out, w_drop;
  logic signed [PROD_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]    w_rnd, w_shift;
  logic [DATA_W-1:0]          w_mix;
  logic                       w_sat;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clk_enable) begin
      case (r_state)
        S_IDLE:  if (sample_valid) w_state_nxt = S_MAC;
        S_MAC:   if (r_k == K_LAST) w_state_nxt = S_OUT;
        S_OUT:   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath strobes; a strobe arriving while not idle is a drop.
  always_comb begin
    w_capture = 1'b0;
    w_mac     = 1'b0;
    w_out     = 1'b0;
    w_drop    = 1'b0;
    if (clk_enable) begin
      case (r_state)
        S_IDLE:  w_capture = sample_valid;
        S_MAC:   begin w_mac = 1'b1; w_drop = sample_valid; end
        S_OUT:   begin w_out = 1'b1; w_drop = sample_valid; end
        default: ;
      endcase
    end
  end

  // Gain bank is written regardless of clk_enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_BANDS); i++) r_gain[i] <= G_UNIT;
    end else if (gain_wr_en && (32'(gain_addr) < NUM_BANDS)) begin
      r_gain[gain_addr] <= gain_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < int'(NUM_BANDS); i++) begin
        r_band[i]   <= band_in[i*DATA_W +: DATA_W];
        r_gain_w[i] <= r_gain[i];
      end
    end
  end

  assign w_prod  = r_band[r_k] * r_gain_w[r_k];
  assign w_rnd   = r_acc + RND;
  assign w_shift = w_rnd >>> FRAC_BITS;

`ifdef EQ_MIX_SATURATE_EN
  always_comb begin
    w_sat = 1'b0;
    w_mix = w_shift[DATA_W-1:0];
    if (w_shift > MAX_V) begin
      w_sat = 1'b1;
      w_mix = DATA_W'(MAX_V);
    end else if (w_shift < MIN_V) begin
      w_sat = 1'b1;
      w_mix = DATA_W'(MIN_V);
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{w_shift[ACC_W-1:DATA_W], MAX_V, MIN_V};
  assign w_sat    = 1'b0;
  assign w_mix    = w_shift[DATA_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_k         <= '0;
      r_mix_out   <= '0;
      r_mix_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
      r_clip      <= 1'b0;
    end else begin
      r_mix_valid <= w_out;
      if (w_capture) begin
        r_acc  <= '0;
        r_k    <= '0;
        r_busy <= 1'b1;
      end
      if (w_mac) begin
        r_acc <= r_acc + ACC_W'(w_prod);
        if (r_k != K_LAST) r_k <= r_k + K_W'(1);
      end
      if (w_out) begin
        r_mix_out <= w_mix;
        r_busy    <= 1'b0;
      end
      // Set events take priority over flag_clr.
      if (w_drop)              r_overrun <= 1'b1;
      else if (flag_clr)       r_overrun <= 1'b0;
      if (w_out && w_sat)      r_clip    <= 1'b1;
      else if (flag_clr)       r_clip    <= 1'b0;
    end
  end

  assign mix_out   = r_mix_out;
  assign mix_valid = r_mix_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
  assign clip      = r_clip;

endmodule

// File: tb/tb_eq_band_mixer.sv
// Directed bench for eq_band_mixer: gain/rounding/reduction vector table plus overrun, stall,
// mid-sample gain write and mid-sample reset sequences.
module tb_eq_band_mixer;

  logic         clk = 1'b0;
  logic         rst, clk_enable, sample_valid, gain_wr_en, flag_clr;
  logic [127:0] band_in;
  logic [2:0]   gain_addr;
  logic [15:0]  gain_data, mix_out;
  logic         mix_valid, busy, overrun, clip;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  eq_band_mixer dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable), .sample_valid(sample_valid),
    .band_in(band_in), .gain_wr_en(gain_wr_en), .gain_addr(gain_addr), .gain_data(gain_data),
    .mix_out(mix_out), .mix_valid(mix_valid), .busy(busy), .overrun(overrun), .clip(clip),
    .flag_clr(flag_clr)
  );

`ifdef EQ_MIX_SATURATE_EN
  localparam logic [15:0] POS_BIG  = 16'h7FFF;
  localparam logic [15:0] NEG_BIG  = 16'h8000;
  localparam logic        CLIP_BIG = 1'b1;
`else
  localparam logic [15:0] POS_BIG  = 16'hFFF8;
  localparam logic [15:0] NEG_BIG  = 16'h0000;
  localparam logic        CLIP_BIG = 1'b0;
`endif

  localparam logic [15:0]  U     = 16'd16384;
  localparam logic [127:0] G_ALL = {8{U}};
  localparam logic [127:0] B_1K  = {8{16'd1000}};

  typedef struct {
    logic [127:0] gains;
    logic [127:0] bands;
    logic [15:0]  exp_out;
    logic         exp_clip;
  } vec_t;

  vec_t vecs [9];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic load_gains(input logic [127:0] g);
    for (int i = 0; i < 8; i++) begin
      gain_wr_en = 1'b1;
      gain_addr  = 3'(i);
      gain_data  = g[i*16 +: 16];
      step;
    end
    gain_wr_en = 1'b0;
  endtask

  task automatic pulse_clr;
    flag_clr = 1'b1;
    step;
    flag_clr = 1'b0;
  endtask

  // Capture a sample, then wait (bounded) for mix_valid; lat counts edges after the capture edge.
  task automatic run_sample(input logic [127:0] b, output logic [15:0] out, output int lat,
                            output bit busy_ok);
    band_in      = b;
    sample_valid = 1'b1;
    step;
    sample_valid = 1'b0;
    lat     = 0;
    busy_ok = 1'b1;
    while (!mix_valid && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      step;
      lat++;
    end
    if (busy) busy_ok = 1'b0;
    out = mix_out;
  endtask

  initial begin
    logic [15:0] out;
    int          lat, pulses;
    bit          bok;

    vecs[0] = '{G_ALL, B_1K, 16'd8000, 1'b0};
    vecs[1] = '{{U, U, U, U, 16'd0, U, U, U}, B_1K, 16'd7000, 1'b0};
    vecs[2] = '{{U, U, U, U, 16'd0, U, U, 16'd8192}, B_1K, 16'd6500, 1'b0};
    vecs[3] = '{{{7{16'd0}}, 16'd8192}, {{7{16'd1000}}, 16'h0001}, 16'h0001, 1'b0};
    vecs[4] = '{{{7{16'd0}}, 16'd8192}, {{7{16'd1000}}, 16'hFFFF}, 16'h0000, 1'b0};
    vecs[5] = '{{{7{16'd0}}, 16'd8192}, {{7{16'd1000}}, 16'hFFFD}, 16'hFFFF, 1'b0};
    vecs[6] = '{G_ALL, {8{16'h7FFF}}, POS_BIG, CLIP_BIG};
    vecs[7] = '{G_ALL, {8{16'h8000}}, NEG_BIG, CLIP_BIG};
    vecs[8] = '{{8{16'hC000}}, B_1K, 16'(-8000), 1'b0};

    rst = 1'b1; clk_enable = 1'b1; sample_valid = 1'b0; gain_wr_en = 1'b0; flag_clr = 1'b0;
    band_in = '0; gain_addr = '0; gain_data = '0;
    step; step;
    rst = 1'b0;
    chk("reset mix_out", 32'(mix_out), 0);
    chk("reset mix_valid", 32'(mix_valid), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset overrun", 32'(overrun), 0);
    chk("reset clip", 32'(clip), 0);

    for (int i = 0; i < 9; i++) begin
      if (i > 0) load_gains(vecs[i].gains);
      run_sample(vecs[i].bands, out, lat, bok);
      chk($sformatf("vec%0d mix_out", i), 32'(out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d latency", i), 32'(lat), 9);
      chk($sformatf("vec%0d busy window", i), 32'(bok), 1);
      step;
      chk($sformatf("vec%0d mix_valid one cycle", i), 32'(mix_valid), 0);
      chk($sformatf("vec%0d mix_out hold", i), 32'(mix_out), 32'(vecs[i].exp_out));
      chk($sformatf("vec%0d clip", i), 32'(clip), 32'(vecs[i].exp_clip));
      pulse_clr;
      chk($sformatf("vec%0d clip cleared", i), 32'(clip), 0);
    end

    // Second strobe two edges into MAC is dropped.
    load_gains(G_ALL);
    band_in = B_1K; sample_valid = 1'b1; step; sample_valid = 1'b0;
    step; step;
    sample_valid = 1'b1; step; sample_valid = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (mix_valid) begin pulses++; out = mix_out; end
      step;
    end
    chk("overrun pulses", 32'(pulses), 1);
    chk("overrun mix_out", 32'(out), 8000);
    chk("overrun flag", 32'(overrun), 1);
    chk("overrun idle after", 32'(busy), 0);
    pulse_clr;
    chk("overrun cleared", 32'(overrun), 0);

    // Five disabled cycles mid-MAC, with an ignored strobe during the stall.
    band_in = {16'd400, 16'd300, 16'd200, 16'd100, 16'd0, 16'hFF9C, 16'hFF38, 16'hFED4};
    sample_valid = 1'b1; step; sample_valid = 1'b0;
    step; step;
    clk_enable = 1'b0; sample_valid = 1'b1;
    for (int c = 0; c < 5; c++) step;
    clk_enable = 1'b1; sample_valid = 1'b0;
    lat = 7;
    while (!mix_valid && lat < 40) begin step; lat++; end
    chk("stall latency", 32'(lat), 14);
    chk("stall mix_out", 32'(mix_out), 400);
    chk("stall no overrun", 32'(overrun), 0);
    step;

    // Gain write in cycle T+2 only affects the following sample.
    band_in = B_1K; sample_valid = 1'b1; step; sample_valid = 1'b0;
    step;
    gain_wr_en = 1'b1; gain_addr = 3'd0; gain_data = 16'd0; step; gain_wr_en = 1'b0;
    lat = 2;
    while (!mix_valid && lat < 40) begin step; lat++; end
    chk("gain-wr latency", 32'(lat), 9);
    chk("gain-wr current", 32'(mix_out), 8000);
    step;
    run_sample(B_1K, out, lat, bok);
    chk("gain-wr next", 32'(out), 7000);
    step;

    // Reset in cycle T+4 aborts the sample and restores unity gains.
    band_in = B_1K; sample_valid = 1'b1; step; sample_valid = 1'b0;
    step; step; step;
    rst = 1'b1; step; rst = 1'b0;
    chk("mid-rst mix_out", 32'(mix_out), 0);
    chk("mid-rst busy", 32'(busy), 0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      if (mix_valid) pulses++;
      step;
    end
    chk("mid-rst no mix_valid", 32'(pulses), 0);
    run_sample(B_1K, out, lat, bok);
    chk("post-rst mix_out", 32'(out), 8000);
    chk("post-rst latency", 32'(lat), 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
